// File: rtl/rv_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : rv_arb_pkg
// Purpose  : Shared arbiter state encoding and abort read-data constant.
// Revision : 1.0 - initial release
// ============================================================================
package rv_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BUSY  = 2'd1,
    ST_ABORT = 2'd2
  } arb_state_t;

  localparam logic [31:0] ABORT_RDATA = 32'h0000_0000;
  localparam int          CNT_W       = 16;

endpackage
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : rr_arbiter
// Purpose  : Combinational round-robin pick: search starts after last grantee.
// Revision : 1.0 - initial release
// ============================================================================
module rr_arbiter #(
  parameter int NUM_REQ = 2
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [NUM_REQ-1:0] i_last,
  output logic [NUM_REQ-1:0] o_gnt
);

  int   w_last_idx;
  int   w_idx;
  logic w_found;

  always_comb begin
    w_last_idx = NUM_REQ - 1;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (i_last[i]) w_last_idx = i;
    end
    o_gnt   = '0;
    w_found = 1'b0;
    w_idx   = 0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      w_idx = (w_last_idx + k) % NUM_REQ;
      for (int j = 0; j < NUM_REQ; j++) begin
        if ((j == w_idx) && !w_found && i_req[j]) begin
          o_gnt[j] = 1'b1;
          w_found  = 1'b1;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/wb_master_arb.sv
`default_nettype none
// ============================================================================
// Module   : wb_master_arb
// Purpose  : Round-robin Wishbone master arbiter with bus lock and ack timeout.
// Revision : 1.0 - initial release
// ============================================================================
module wb_master_arb
  import rv_arb_pkg::*;
#(
  parameter int NUM_MASTERS = 2,
  parameter int TIMEOUT     = 255
) (
  input  logic                        i_clk,
  input  logic                        i_reset_n,
  input  logic [NUM_MASTERS-1:0]      i_m_cyc,
  input  logic [NUM_MASTERS-1:0]      i_m_stb,
  input  logic [NUM_MASTERS-1:0]      i_m_we,
  input  logic [NUM_MASTERS-1:0][31:0] i_m_adr,
  input  logic [NUM_MASTERS-1:0][31:0] i_m_dat,
  input  logic [NUM_MASTERS-1:0][3:0] i_m_sel,
  output logic [NUM_MASTERS-1:0]      o_m_ack,
  output logic [NUM_MASTERS-1:0]      o_m_err,
  output logic [31:0]                 o_m_dat,
  output logic [31:0]                 o_wb_adr,
  output logic [31:0]                 o_wb_dat,
  output logic [3:0]                  o_wb_sel,
  output logic                        o_wb_we,
  output logic                        o_wb_stb,
  output logic                        o_wb_cyc,
  input  logic [31:0]                 i_wb_dat,
  input  logic                        i_wb_ack,
  output logic [NUM_MASTERS-1:0]      o_grant
);

  localparam logic [CNT_W-1:0]       c_TMO_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [NUM_MASTERS-1:0] c_LAST_RST = {1'b1, {(NUM_MASTERS-1){1'b0}}};

  arb_state_t             r_state, w_state_nxt;
  logic [NUM_MASTERS-1:0] r_grant, w_grant_nxt;
  logic [NUM_MASTERS-1:0] r_last, w_last_nxt;
  logic [NUM_MASTERS-1:0] w_rr_gnt;
  logic [CNT_W-1:0]       r_cnt, w_cnt_nxt;

  logic        w_sel_cyc, w_sel_stb, w_sel_we;
  logic [31:0] w_sel_adr, w_sel_dat;
  logic [3:0]  w_sel_sel;

  rr_arbiter #(.NUM_REQ(NUM_MASTERS)) u_rr_arbiter (
    .i_req (i_m_cyc),
    .i_last(r_last),
    .o_gnt (w_rr_gnt)
  );

  // Grant is one-hot, so OR-ing the selected lanes forms the mux.
  always_comb begin
    w_sel_cyc = 1'b0;
    w_sel_stb = 1'b0;
    w_sel_we  = 1'b0;
    w_sel_adr = '0;
    w_sel_dat = '0;
    w_sel_sel = '0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      if (r_grant[i]) begin
        w_sel_cyc = w_sel_cyc | i_m_cyc[i];
        w_sel_stb = w_sel_stb | i_m_stb[i];
        w_sel_we  = w_sel_we  | i_m_we[i];
        w_sel_adr = w_sel_adr | i_m_adr[i];
        w_sel_dat = w_sel_dat | i_m_dat[i];
        w_sel_sel = w_sel_sel | i_m_sel[i];
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state <= ST_IDLE;
      r_grant <= '0;
      r_last  <= c_LAST_RST;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_grant <= w_grant_nxt;
      r_last  <= w_last_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_grant_nxt = r_grant;
    w_last_nxt  = r_last;
    w_cnt_nxt   = r_cnt;
    o_m_ack     = '0;
    o_m_err     = '0;
    o_m_dat     = '0;
    o_wb_adr    = '0;
    o_wb_dat    = '0;
    o_wb_sel    = '0;
    o_wb_we     = 1'b0;
    o_wb_stb    = 1'b0;
    o_wb_cyc    = 1'b0;
    o_grant     = '0;
    case (r_state)
      ST_IDLE: begin
        w_cnt_nxt = '0;
        if (|i_m_cyc) begin
          w_grant_nxt = w_rr_gnt;
          w_last_nxt  = w_rr_gnt;
          w_state_nxt = ST_BUSY;
        end
      end
      ST_BUSY: begin
        o_grant  = r_grant;
        o_wb_cyc = w_sel_cyc;
        o_wb_stb = w_sel_stb;
        o_wb_we  = w_sel_we;
        o_wb_adr = w_sel_adr;
        o_wb_dat = w_sel_dat;
        o_wb_sel = w_sel_sel;
        o_m_ack  = r_grant & {NUM_MASTERS{i_wb_ack}};
        o_m_dat  = i_wb_dat;
        if (!w_sel_cyc) begin
          w_state_nxt = ST_IDLE;
          w_grant_nxt = '0;
          w_cnt_nxt   = '0;
        end else if (i_wb_ack || !w_sel_stb) begin
          w_cnt_nxt = '0;
        // This cycle's wait would make the count reach TIMEOUT; an ack here wins.
        end else if (r_cnt == c_TMO_LAST) begin
          w_state_nxt = ST_ABORT;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      ST_ABORT: begin
        o_grant     = r_grant;
        o_m_ack     = r_grant;
        o_m_err     = r_grant;
        o_m_dat     = ABORT_RDATA;
        w_state_nxt = ST_IDLE;
        w_grant_nxt = '0;
        w_cnt_nxt   = '0;
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_grant_nxt = '0;
        w_cnt_nxt   = '0;
      end
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_wb_master_arb.sv
`default_nettype none
// ============================================================================
// Module   : tb_wb_master_arb
// Purpose  : Directed self-checking bench for wb_master_arb (2 masters, TIMEOUT 8).
// Revision : 1.0 - initial release
// ============================================================================
module tb_wb_master_arb;

  localparam int NM = 2;

  logic               i_clk = 1'b0;
  logic               i_reset_n;
  logic [NM-1:0]      i_m_cyc, i_m_stb, i_m_we;
  logic [NM-1:0][31:0] i_m_adr, i_m_dat;
  logic [NM-1:0][3:0] i_m_sel;
  logic [NM-1:0]      o_m_ack, o_m_err;
  logic [31:0]        o_m_dat;
  logic [31:0]        o_wb_adr, o_wb_dat;
  logic [3:0]         o_wb_sel;
  logic               o_wb_we, o_wb_stb, o_wb_cyc;
  logic [31:0]        i_wb_dat;
  logic               i_wb_ack;
  logic [NM-1:0]      o_grant;

  int n_pass  = 0;
  int n_total = 0;

  wb_master_arb #(.NUM_MASTERS(NM), .TIMEOUT(8)) dut (
    .i_clk    (i_clk),
    .i_reset_n(i_reset_n),
    .i_m_cyc  (i_m_cyc),
    .i_m_stb  (i_m_stb),
    .i_m_we   (i_m_we),
    .i_m_adr  (i_m_adr),
    .i_m_dat  (i_m_dat),
    .i_m_sel  (i_m_sel),
    .o_m_ack  (o_m_ack),
    .o_m_err  (o_m_err),
    .o_m_dat  (o_m_dat),
    .o_wb_adr (o_wb_adr),
    .o_wb_dat (o_wb_dat),
    .o_wb_sel (o_wb_sel),
    .o_wb_we  (o_wb_we),
    .o_wb_stb (o_wb_stb),
    .o_wb_cyc (o_wb_cyc),
    .i_wb_dat (i_wb_dat),
    .i_wb_ack (i_wb_ack),
    .o_grant  (o_grant)
  );

  always #5 i_clk = ~i_clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs !== exp) $display("FAIL %s: got %h expected %h", tag, obs, exp);
    else n_pass++;
  endtask

  // Inputs change at the falling edge; checks sample 1 time unit later.
  task automatic step();
    @(negedge i_clk);
  endtask

  task automatic drive_m(input int m, input logic cyc, input logic stb, input logic we,
                         input logic [31:0] adr, input logic [31:0] dat);
    i_m_cyc[m] = cyc;
    i_m_stb[m] = stb;
    i_m_we[m]  = we;
    i_m_adr[m] = adr;
    i_m_dat[m] = dat;
    i_m_sel[m] = 4'hF;
  endtask

  task automatic do_reset();
    step();
    i_reset_n = 1'b0;
    step();
    step();
    i_reset_n = 1'b1;
  endtask

  initial begin
    i_reset_n = 1'b0;
    i_m_cyc = '0; i_m_stb = '0; i_m_we = '0;
    i_m_adr = '0; i_m_dat = '0; i_m_sel = '0;
    i_wb_dat = '0; i_wb_ack = 1'b0;
    step(); step();
    #1;
    chk("rst_grant", 32'(o_grant), 32'h0);
    chk("rst_cyc", 32'(o_wb_cyc), 32'h0);
    chk("rst_ack", 32'(o_m_ack), 32'h0);
    i_reset_n = 1'b1;

    // Single master write, ack two cycles after grant
    step();
    drive_m(0, 1, 1, 1, 32'h1000_0000, 32'h55);
    #1 chk("w_cyc_idle", 32'(o_wb_cyc), 32'h0);
    step(); #1;
    chk("w_cyc_busy", 32'(o_wb_cyc), 32'h1);
    chk("w_grant", 32'(o_grant), 32'h1);
    chk("w_adr", o_wb_adr, 32'h1000_0000);
    chk("w_dat", o_wb_dat, 32'h55);
    chk("w_we", 32'(o_wb_we), 32'h1);
    chk("w_noack1", 32'(o_m_ack), 32'h0);
    step(); #1 chk("w_noack2", 32'(o_m_ack), 32'h0);
    step(); i_wb_ack = 1'b1;
    #1 chk("w_ack", 32'(o_m_ack), 32'h1);
    step(); i_wb_ack = 1'b0; drive_m(0, 0, 0, 0, 0, 0);
    #1 chk("w_ack_once", 32'(o_m_ack), 32'h0);
    chk("w_cyc_drop", 32'(o_wb_cyc), 32'h0);
    step(); #1 chk("w_idle_grant", 32'(o_grant), 32'h0);

    // Contention from reset: 0, dead cycle, 1, then 0 again
    do_reset();
    drive_m(0, 1, 1, 0, 32'hA0, 0);
    drive_m(1, 1, 1, 0, 32'hB0, 0);
    step(); #1;
    chk("c_grant0", 32'(o_grant), 32'h1);
    chk("c_adr0", o_wb_adr, 32'hA0);
    i_wb_ack = 1'b1;
    #1 chk("c_ack_only0", 32'(o_m_ack), 32'h1);
    step(); i_wb_ack = 1'b0; drive_m(0, 0, 0, 0, 0, 0);
    #1 chk("c_drop_cyc", 32'(o_wb_cyc), 32'h0);
    step(); #1 chk("c_dead", 32'(o_grant), 32'h0);
    step(); #1;
    chk("c_grant1", 32'(o_grant), 32'h2);
    chk("c_adr1", o_wb_adr, 32'hB0);
    drive_m(1, 0, 0, 0, 0, 0);
    drive_m(0, 1, 1, 0, 32'hA4, 0);
    step(); drive_m(1, 1, 1, 0, 32'hB4, 0);
    step(); #1 chk("c_grant0_again", 32'(o_grant), 32'h1);
    drive_m(0, 0, 0, 0, 0, 0); drive_m(1, 0, 0, 0, 0, 0);
    step(); step();

    // Bus lock: master 1 does three reads while master 0 waits
    drive_m(1, 1, 1, 0, 32'hC0, 0);
    step(); #1 chk("l_grant1", 32'(o_grant), 32'h2);
    drive_m(0, 1, 1, 0, 32'hD0, 0);
    for (int k = 1; k <= 3; k++) begin
      step(); i_wb_ack = 1'b1; i_wb_dat = 32'(k);
      #1;
      chk($sformatf("l_rdata%0d", k), o_m_dat, 32'(k));
      chk($sformatf("l_ack%0d", k), 32'(o_m_ack), 32'h2);
      step(); i_wb_ack = 1'b0;
      #1 chk($sformatf("l_hold%0d", k), 32'(o_grant), 32'h2);
    end
    step(); drive_m(1, 0, 0, 0, 0, 0);
    #1 chk("l_m0_noack", 32'(o_m_ack), 32'h0);
    step(); #1 chk("l_dead", 32'(o_grant), 32'h0);
    step(); #1 chk("l_grant0", 32'(o_grant), 32'h1);
    drive_m(0, 0, 0, 0, 0, 0);
    step(); step();

    // Timeout: no ack for 8 busy strobe cycles
    i_wb_dat = 32'hDEAD_BEEF;
    drive_m(0, 1, 1, 0, 32'hE0, 0);
    for (int c = 1; c <= 8; c++) begin
      step(); #1;
      if (c == 8) chk("t_no_err_yet", 32'(o_m_err), 32'h0);
    end
    step(); #1;
    chk("t_err", 32'(o_m_err), 32'h1);
    chk("t_ack", 32'(o_m_ack), 32'h1);
    chk("t_dat", o_m_dat, 32'h0);
    chk("t_cyc", 32'(o_wb_cyc), 32'h0);
    step(); drive_m(0, 0, 0, 0, 0, 0);
    #1;
    chk("t_idle", 32'(o_grant), 32'h0);
    chk("t_err_clr", 32'(o_m_err), 32'h0);
    step(); step();

    // Ack on the exact timeout cycle wins over abort
    drive_m(0, 1, 1, 0, 32'hE4, 0);
    for (int c = 1; c <= 7; c++) step();
    step(); i_wb_ack = 1'b1;
    #1;
    chk("e_ack", 32'(o_m_ack), 32'h1);
    chk("e_err", 32'(o_m_err), 32'h0);
    step(); i_wb_ack = 1'b0;
    #1;
    chk("e_no_abort", 32'(o_m_err), 32'h0);
    chk("e_still_busy", 32'(o_grant), 32'h1);
    drive_m(0, 0, 0, 0, 0, 0);
    step(); step();

    // Reset mid-transfer: last grantee is 0, so master 1 wins before reset
    drive_m(1, 1, 1, 1, 32'hF0, 32'h77);
    step(); #1 chk("r_grant1", 32'(o_grant), 32'h2);
    step(); i_wb_ack = 1'b1; i_reset_n = 1'b0;
    #1;
    chk("r_ack", 32'(o_m_ack), 32'h0);
    chk("r_err", 32'(o_m_err), 32'h0);
    chk("r_cyc", 32'(o_wb_cyc), 32'h0);
    chk("r_adr", o_wb_adr, 32'h0);
    chk("r_grant", 32'(o_grant), 32'h0);
    step(); i_wb_ack = 1'b0; i_reset_n = 1'b1;
    drive_m(0, 1, 1, 0, 32'hA8, 0);
    step(); #1 chk("r_first_win0", 32'(o_grant), 32'h1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
